// File: rtl/npu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : npu_pkg                                                      |
// | Description : Shared NPU types and default widths. Holds the fetch state   |
// |               encoding and a helper for index widths.                      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package npu_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int DIM_W_DEF  = 10;
  localparam int ADDR_W_DEF = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } fetch_state_e;

  // Bits needed to index n items; never less than one so the counter and
  // slot buses stay legal for a 1x1 tile.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/block_fetch_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : block_fetch_if                                               |
// | Description : Bundle of request, memory-read and tile-output signals for   |
// |               block_fetch.                                                 |
// |   master : requester + memory side (drives start/coords, mem_rd_data,      |
// |            out_ready; observes read strobe/address, block, out_valid)      |
// |   slave  : the fetcher itself                                              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface block_fetch_if
  import npu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int J      = 2,
  parameter int K      = 2,
  parameter int DIM_W  = DIM_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);
  logic                    start;
  logic [DIM_W-1:0]        start_row;
  logic [DIM_W-1:0]        start_col;
  logic [DIM_W-1:0]        num_rows;
  logic [DIM_W-1:0]        num_cols;
  logic [ADDR_W-1:0]       base_addr;
  logic                    transpose;
  logic                    mem_rd_en;
  logic [ADDR_W-1:0]       mem_rd_addr;
  logic [DATA_W-1:0]       mem_rd_data;
  logic [J*K*DATA_W-1:0]   block;
  logic                    out_valid;
  logic                    out_ready;
  logic                    busy;

  modport master (
    output start, start_row, start_col, num_rows, num_cols, base_addr, transpose,
    output mem_rd_data, out_ready,
    input  mem_rd_en, mem_rd_addr, block, out_valid, busy
  );

  modport slave (
    input  start, start_row, start_col, num_rows, num_cols, base_addr, transpose,
    input  mem_rd_data, out_ready,
    output mem_rd_en, mem_rd_addr, block, out_valid, busy
  );
endinterface
`default_nettype wire

// File: rtl/block_addr_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : block_addr_gen                                               |
// | Description : Combinational element mapper. For tile element e returns     |
// |               the memory address, whether the source lies inside the       |
// |               matrix, and the destination slot in the flat tile.           |
// |   in  : e, start_row, start_col, num_rows, num_cols, base_addr, transpose  |
// |   out : addr, in_bounds, slot                                              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module block_addr_gen
  import npu_pkg::*;
#(
  parameter int J      = 2,
  parameter int K      = 2,
  parameter int DIM_W  = DIM_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int EW     = 2,
  parameter int SW     = 2
) (
  input  logic [EW-1:0]     e,
  input  logic [DIM_W-1:0]  start_row,
  input  logic [DIM_W-1:0]  start_col,
  input  logic [DIM_W-1:0]  num_rows,
  input  logic [DIM_W-1:0]  num_cols,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              transpose,
  output logic [ADDR_W-1:0] addr,
  output logic              in_bounds,
  output logic [SW-1:0]     slot
);
  localparam int PW = 2*DIM_W + 2;

  logic [31:0]      row_off;
  logic [31:0]      col_off;
  logic [DIM_W:0]   src_r;
  logic [DIM_W:0]   src_c;
  logic [PW-1:0]    lin;

  always_comb begin
    row_off   = 32'(e) / 32'(K);
    col_off   = 32'(e) % 32'(K);
    // One extra bit so start + offset can never wrap back into range.
    src_r     = {1'b0, start_row} + (DIM_W+1)'(row_off);
    src_c     = {1'b0, start_col} + (DIM_W+1)'(col_off);
    in_bounds = (src_r < {1'b0, num_rows}) && (src_c < {1'b0, num_cols});
    lin       = PW'(src_r) * PW'(num_cols) + PW'(src_c);
    // Address deliberately wraps at the memory width.
    addr      = base_addr + ADDR_W'(lin);
    slot      = transpose ? SW'(col_off * 32'(J) + row_off)
                          : SW'(row_off * 32'(K) + col_off);
  end
endmodule
`default_nettype wire

// File: rtl/block_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : block_fetch                                                  |
// | Description : J x K tile fetcher from a synchronous-read, row-major        |
// |               matrix memory into a flat tile register, with optional       |
// |               transpose and zero padding of out-of-range elements.         |
// |   clk, rst_n : clock, asynchronous active-low reset                        |
// |   bus        : block_fetch_if.slave (request, memory read, tile output)    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module block_fetch
  import npu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int J      = 2,
  parameter int K      = 2,
  parameter int DIM_W  = DIM_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  block_fetch_if.slave  bus
);
  localparam int N  = J * K;
  localparam int EW = idx_w(N);
  localparam int SW = idx_w(N);
  localparam int BW = N * DATA_W;

  fetch_state_e      state_q, state_d;
  logic [EW-1:0]     e_q, e_d;
  logic [DIM_W-1:0]  row_q, row_d, col_q, col_d;
  logic [DIM_W-1:0]  nrows_q, nrows_d, ncols_q, ncols_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              tr_q, tr_d;
  logic              mem_rd_en_q, mem_rd_en_d;
  logic [ADDR_W-1:0] mem_rd_addr_q, mem_rd_addr_d;
  // Stage a travels with the read strobe; stage b lines up with returned data.
  logic              a_vld_q, a_vld_d, a_inb_q, a_inb_d;
  logic [SW-1:0]     a_slot_q, a_slot_d;
  logic              b_vld_q, b_vld_d, b_inb_q, b_inb_d;
  logic [SW-1:0]     b_slot_q, b_slot_d;
  logic [BW-1:0]     block_q, block_d;
  logic              out_valid_q, out_valid_d;
  logic              busy_q, busy_d;

  logic              start_ok;
  logic              accept;
  logic [EW-1:0]     gen_e;
  logic [DIM_W-1:0]  gen_row, gen_col, gen_nrows, gen_ncols;
  logic [ADDR_W-1:0] gen_base;
  logic              gen_tr;
  logic [ADDR_W-1:0] gen_addr;
  logic              gen_inb;
  logic [SW-1:0]     gen_slot;

  // The read strobe is registered, so the mapper always works one element
  // ahead: on acceptance it maps element 0 from the live request, during
  // ISSUE it maps e_q+1 from the captured request.
  always_comb begin
    start_ok  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && bus.out_ready);
    accept    = bus.start && start_ok;
    gen_e     = accept ? '0 : (e_q + EW'(1));
    gen_row   = accept ? bus.start_row : row_q;
    gen_col   = accept ? bus.start_col : col_q;
    gen_nrows = accept ? bus.num_rows  : nrows_q;
    gen_ncols = accept ? bus.num_cols  : ncols_q;
    gen_base  = accept ? bus.base_addr : base_q;
    gen_tr    = accept ? bus.transpose : tr_q;
  end

  block_addr_gen #(
    .J      (J),
    .K      (K),
    .DIM_W  (DIM_W),
    .ADDR_W (ADDR_W),
    .EW     (EW),
    .SW     (SW)
  ) u_addr_gen (
    .e         (gen_e),
    .start_row (gen_row),
    .start_col (gen_col),
    .num_rows  (gen_nrows),
    .num_cols  (gen_ncols),
    .base_addr (gen_base),
    .transpose (gen_tr),
    .addr      (gen_addr),
    .in_bounds (gen_inb),
    .slot      (gen_slot)
  );

  always_comb begin
    state_d       = state_q;
    e_d           = e_q;
    row_d         = row_q;
    col_d         = col_q;
    nrows_d       = nrows_q;
    ncols_d       = ncols_q;
    base_d        = base_q;
    tr_d          = tr_q;
    mem_rd_en_d   = 1'b0;
    mem_rd_addr_d = mem_rd_addr_q;
    a_vld_d       = 1'b0;
    a_inb_d       = 1'b0;
    a_slot_d      = a_slot_q;
    b_vld_d       = a_vld_q;
    b_inb_d       = a_inb_q;
    b_slot_d      = a_slot_q;
    block_d       = block_q;

    // Every slot is written exactly once per fetch, so no clear is needed.
    if (b_vld_q) begin
      block_d[b_slot_q*DATA_W +: DATA_W] = b_inb_q ? bus.mem_rd_data : '0;
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept) begin
          state_d = ST_ISSUE;
          e_d     = '0;
          row_d   = bus.start_row;
          col_d   = bus.start_col;
          nrows_d = bus.num_rows;
          ncols_d = bus.num_cols;
          base_d  = bus.base_addr;
          tr_d    = bus.transpose;
        end else if (state_q == ST_DONE && bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (e_q == EW'(N - 1)) begin
          state_d = ST_DRAIN;
        end else begin
          e_d = e_q + EW'(1);
        end
      end
      default: begin
        state_d = ST_DONE;
      end
    endcase

    if (accept || (state_q == ST_ISSUE && e_q != EW'(N - 1))) begin
      mem_rd_en_d = gen_inb;
      if (gen_inb) begin
        mem_rd_addr_d = gen_addr;
      end
      a_vld_d  = 1'b1;
      a_inb_d  = gen_inb;
      a_slot_d = gen_slot;
    end

    out_valid_d = (state_d == ST_DONE);
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      e_q           <= '0;
      row_q         <= '0;
      col_q         <= '0;
      nrows_q       <= '0;
      ncols_q       <= '0;
      base_q        <= '0;
      tr_q          <= 1'b0;
      mem_rd_en_q   <= 1'b0;
      mem_rd_addr_q <= '0;
      a_vld_q       <= 1'b0;
      a_inb_q       <= 1'b0;
      a_slot_q      <= '0;
      b_vld_q       <= 1'b0;
      b_inb_q       <= 1'b0;
      b_slot_q      <= '0;
      block_q       <= '0;
      out_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      e_q           <= e_d;
      row_q         <= row_d;
      col_q         <= col_d;
      nrows_q       <= nrows_d;
      ncols_q       <= ncols_d;
      base_q        <= base_d;
      tr_q          <= tr_d;
      mem_rd_en_q   <= mem_rd_en_d;
      mem_rd_addr_q <= mem_rd_addr_d;
      a_vld_q       <= a_vld_d;
      a_inb_q       <= a_inb_d;
      a_slot_q      <= a_slot_d;
      b_vld_q       <= b_vld_d;
      b_inb_q       <= b_inb_d;
      b_slot_q      <= b_slot_d;
      block_q       <= block_d;
      out_valid_q   <= out_valid_d;
      busy_q        <= busy_d;
    end
  end

  assign bus.mem_rd_en   = mem_rd_en_q;
  assign bus.mem_rd_addr = mem_rd_addr_q;
  assign bus.block       = block_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.busy        = busy_q;
endmodule
`default_nettype wire

// File: tb/tb_block_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_block_fetch                                               |
// | Description : Directed bench for block_fetch (J=K=2) with a synchronous    |
// |               memory model holding mem[a] = 0x1000 + a.                    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_block_fetch;
  import npu_pkg::*;

  localparam int DATA_W = 16;
  localparam int J      = 2;
  localparam int K      = 2;
  localparam int DIM_W  = 10;
  localparam int ADDR_W = 10;

  logic clk = 1'b0;
  logic rst_n;
  int   pc = 0;
  int   chk_cnt = 0;
  int   pass_cnt = 0;

  logic [DATA_W-1:0] mem [1 << ADDR_W];

  logic [63:0]       exp_blk_q  [$];
  int                exp_vcyc_q [$];
  logic [ADDR_W-1:0] exp_addr_q [$];

  logic        ov_prev = 1'b0;
  logic [63:0] blk_prev = '0;

  block_fetch_if #(.DATA_W(DATA_W), .J(J), .K(K), .DIM_W(DIM_W), .ADDR_W(ADDR_W)) bf ();

  block_fetch #(.DATA_W(DATA_W), .J(J), .K(K), .DIM_W(DIM_W), .ADDR_W(ADDR_W)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) pc <= pc + 1;

  always @(posedge clk) begin
    if (bf.mem_rd_en) bf.mem_rd_data <= mem[bf.mem_rd_addr];
  end

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, pc);
  endtask

  task automatic fail_now(input string name);
    chk_cnt++;
    $display("FAIL %s: event missing or unexpected (cycle %0d)", name, pc);
  endtask

  // Monitor: compares read addresses, out_valid latency, tile contents at the
  // handshake, and tile stability while out_valid is held.
  always @(negedge clk) begin
    if (!rst_n) begin
      ov_prev = 1'b0;
    end else begin
      if (bf.mem_rd_en) begin
        if (exp_addr_q.size() == 0) fail_now("unexpected_read");
        else check("rd_addr", bf.mem_rd_addr, exp_addr_q.pop_front());
      end
      if (bf.out_valid && !ov_prev) begin
        if (exp_vcyc_q.size() == 0) fail_now("unexpected_valid");
        else check("valid_cycle", pc, exp_vcyc_q.pop_front());
      end
      if (bf.out_valid && ov_prev) check("block_stable", bf.block, blk_prev);
      if (bf.out_valid && bf.out_ready) begin
        if (exp_blk_q.size() == 0) fail_now("unexpected_handshake");
        else check("block", bf.block, exp_blk_q.pop_front());
      end
      ov_prev  = bf.out_valid;
      blk_prev = bf.block;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int sr, input int sc, input int nr, input int nc,
                         input int base, input logic tr);
    bf.start_row = DIM_W'(sr);
    bf.start_col = DIM_W'(sc);
    bf.num_rows  = DIM_W'(nr);
    bf.num_cols  = DIM_W'(nc);
    bf.base_addr = ADDR_W'(base);
    bf.transpose = tr;
  endtask

  task automatic push_exp(input logic [63:0] blk, input int na,
                          input int a0, input int a1, input int a2, input int a3);
    int a [4];
    a = '{a0, a1, a2, a3};
    for (int i = 0; i < na; i++) exp_addr_q.push_back(ADDR_W'(a[i]));
    exp_blk_q.push_back(blk);
    exp_vcyc_q.push_back(pc + J*K + 2);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bf.busy && n < 40) begin
      tick();
      n++;
    end
    if (bf.busy) fail_now("idle_timeout");
  endtask

  task automatic run_fetch(input int sr, input int sc, input int nr, input int nc,
                           input int base, input logic tr, input logic [63:0] blk,
                           input int na, input int a0, input int a1, input int a2, input int a3);
    set_req(sr, sc, nr, nc, base, tr);
    bf.start = 1'b1;
    push_exp(blk, na, a0, a1, a2, a3);
    tick();
    bf.start = 1'b0;
    wait_idle();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_block"},     bf.block, 0);
    check({tag, "_out_valid"}, bf.out_valid, 0);
    check({tag, "_mem_rd_en"}, bf.mem_rd_en, 0);
    check({tag, "_rd_addr"},   bf.mem_rd_addr, 0);
    check({tag, "_busy"},      bf.busy, 0);
  endtask

  initial begin
    int n;
    for (int a = 0; a < (1 << ADDR_W); a++) mem[a] = DATA_W'(16'h1000 + a);
    rst_n        = 1'b0;
    bf.start     = 1'b0;
    bf.out_ready = 1'b1;
    set_req(0, 0, 0, 0, 0, 1'b0);
    tick();
    tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    // 4x4 at base 0, tile at (1,1)
    run_fetch(1, 1, 4, 4, 0, 1'b0, {16'h100a, 16'h1009, 16'h1006, 16'h1005}, 4, 5, 6, 9, 10);
    // same tile, transposed
    run_fetch(1, 1, 4, 4, 0, 1'b1, {16'h100a, 16'h1006, 16'h1009, 16'h1005}, 4, 5, 6, 9, 10);
    // 3x3 corner: only (2,2) in range
    run_fetch(2, 2, 3, 3, 0, 1'b0, {16'h0000, 16'h0000, 16'h0000, 16'h1008}, 1, 8, 0, 0, 0);
    // zero-width matrix: no reads, all zero, same latency
    run_fetch(0, 0, 4, 0, 0, 1'b0, 64'h0, 0, 0, 0, 0, 0);
    // address wrap at the top of memory
    run_fetch(0, 0, 2, 2, 1022, 1'b0, {16'h1001, 16'h1000, 16'h13ff, 16'h13fe}, 4, 1022, 1023, 0, 1);

    // back-pressure: hold out_ready low, stray start ignored, then back-to-back
    bf.out_ready = 1'b0;
    set_req(0, 0, 4, 4, 0, 1'b0);
    bf.start = 1'b1;
    push_exp({16'h1005, 16'h1004, 16'h1001, 16'h1000}, 4, 0, 1, 4, 5);
    tick();
    bf.start = 1'b0;
    n = 0;
    while (!bf.out_valid && n < 20) begin
      tick();
      n++;
    end
    if (!bf.out_valid) fail_now("hold_valid_timeout");
    for (int k = 0; k < 10; k++) begin
      if (k == 3) begin
        set_req(1, 1, 4, 4, 0, 1'b1);
        bf.start = 1'b1;
      end else begin
        bf.start = 1'b0;
      end
      tick();
    end
    check("hold_out_valid", bf.out_valid, 1);
    set_req(2, 2, 4, 4, 0, 1'b1);
    bf.out_ready = 1'b1;
    bf.start     = 1'b1;
    push_exp({16'h100f, 16'h100b, 16'h100e, 16'h100a}, 4, 10, 11, 14, 15);
    tick();
    bf.start = 1'b0;
    check("b2b_rd_en", bf.mem_rd_en, 1);
    check("b2b_valid_low", bf.out_valid, 0);
    wait_idle();

    // reset during cycle 3 of a fetch
    set_req(1, 1, 4, 4, 0, 1'b0);
    bf.start = 1'b1;
    exp_addr_q.push_back(ADDR_W'(5));
    exp_addr_q.push_back(ADDR_W'(6));
    tick();
    bf.start = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    check("abort_reads_seen", exp_addr_q.size(), 0);
    exp_addr_q.delete();
    exp_blk_q.delete();
    exp_vcyc_q.delete();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("post_reset_busy", bf.busy, 0);
    run_fetch(0, 1, 4, 4, 0, 1'b1, {16'h1006, 16'h1002, 16'h1005, 16'h1001}, 4, 1, 2, 5, 6);

    tick();
    tick();
    check("end_addr_q", exp_addr_q.size(), 0);
    check("end_blk_q", exp_blk_q.size(), 0);
    check("end_vcyc_q", exp_vcyc_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end
endmodule
`default_nettype wire

// File: doc/block_fetch.md
# block_fetch

Parametrised tile fetcher that copies a J×K block out of a row-major matrix held in an external synchronous-read memory into a flat output register. Element order is configurable (normal or transposed), and out-of-range elements are zero-padded. It sits between the matrix buffer memory and the systolic/MAC datapath. Each fetch is a start pulse plus an output valid/ready handshake.

## Interface
- DATA_W, 16, element width in bits
- J, 2, tile rows
- K, 2, tile columns
- DIM_W, 10, width of row/column coordinates and dimensions
- ADDR_W, 10, memory word-address width
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  fetch request; accepted only when `start_ok` is high
- start_row, start_col  in  DIM_W each  top-left tile coordinate
- num_rows, num_cols  in  DIM_W each  matrix dimensions
- base_addr  in  ADDR_W  address of matrix element (0,0)
- transpose  in  1  1 = store the tile transposed
- mem_rd_en  out  1  memory read strobe (registered)
- mem_rd_addr  out  ADDR_W  memory read address (registered)
- mem_rd_data  in  DATA_W  read data, valid exactly one cycle after `mem_rd_en`
- block  out  J*K*DATA_W  tile; slot s occupies bits [s*DATA_W +: DATA_W]
- out_valid  out  1  tile complete and stable
- out_ready  in  1  consumer accepts the tile
- busy  out  1  state ≠ IDLE

## Operation
- States:
  - IDLE: `start` → ISSUE, capturing all inputs and setting e=0.
  - ISSUE: runs for J*K cycles, one element per cycle.
  - DRAIN: lasts 1 cycle.
  - DONE: `out_valid`=1. `out_ready` → IDLE. `out_ready`&`start` → ISSUE (back-to-back).
- `start_ok` = (IDLE) | (DONE & out_ready). A `start` at any other time is ignored, with no effect and no error.
- Element e uses row-major coordinates i=e/K, j=e%K. It reads source (r,c) = (start_row+i, start_col+j).
- Bounds check: in-bounds if r<num_rows and c<num_cols.
  - The check is computed at DIM_W+1 bits, so the coordinate sum never wraps.
- In-bounds element: issue a read at address base_addr + r*num_cols + c.
  - The address is computed at ADDR_W bits and wraps modulo 2^ADDR_W.
- Out-of-bounds element: no read is issued (`mem_rd_en`=0 that cycle), and the slot is written with 0.
- Destination slot: s = i*K+j when transpose=0, or s = j*J+i when transpose=1 (a K×J tile, row-major).
- Returning data is written using the slot and in-bounds flag delayed by one cycle alongside `mem_rd_en`.
- `block` must not change while `out_valid`=1.
  - Slots are overwritten only during ISSUE/DRAIN of a newly accepted fetch.
- num_rows=0 or num_cols=0: all slots become zero, no reads are issued, and latency is unchanged.

## Timing
- Cycle 0: `start` is sampled.
- Cycles 1..J*K: `mem_rd_en`/`mem_rd_addr` for element e=cycle−1.
- Cycle J*K+1: DRAIN; the last data is captured.
- Cycle J*K+2: `out_valid`=1.
- Latency is fixed at J*K+2 cycles, independent of bounds.
- Handshake completes on a rising edge with `out_valid`&`out_ready`. `out_valid` falls the next cycle unless a back-to-back start was taken, in which case `out_valid` is low for J*K+1 cycles.
- Reset values: `block`=0, `out_valid`=0, `mem_rd_en`=0, `mem_rd_addr`=0, `busy`=0, state=IDLE.
- `rst_n` low mid-fetch aborts immediately.
  - All outputs return to reset values asynchronously.
  - A read response arriving after reset release is discarded.

## Structure
- Shared package `npu_pkg`: state enumeration (IDLE, ISSUE, DRAIN, DONE) and default DATA_W/DIM_W/ADDR_W constants.
- Sub-module `block_addr_gen`: combinational; maps (e, start_row, start_col, num_rows, num_cols, base_addr, transpose) → (addr, in_bounds, slot).
- The top level holds the FSM, the element counter, the one-stage response pipeline and the tile register. RTL size is 150–250 lines.

## Test plan
- J=K=2, 4×4 matrix containing values 0..15 at base 0, start (1,1), transpose=0.
  - Reads go to addresses 5,6,9,10.
  - block = {5,6,9,10} in slots 0..3.
  - `out_valid` is high at cycle 6.
- Same fetch with transpose=1 → slots 0..3 = {5,9,6,10}.
- 3×3 matrix, start (2,2).
  - Exactly one read is issued, at address 8.
  - block = {8,0,0,0}; latency is still 6.
- Hold `out_ready`=0 for 10 cycles.
  - `block` stays stable and `out_valid` stays high.
  - A `start` pulse during that time is ignored.
  - Then `out_ready`=1 together with `start` → new fetch begins; reads resume the next cycle.
- Drop `rst_n` during cycle 3 of a fetch.
  - Outputs clear immediately.
  - After release: IDLE; a fresh fetch completes correctly with no stale data.
- base_addr = 2^ADDR_W−2 → addresses wrap to 0,1; data is placed correctly.
